// File: rtl/eth_tx_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_streamer
// Purpose  : Packet buffer plus AXI-stream frame source feeding the RGMII MAC TX.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_frame_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int BUF_BYTES  = 2048,
    parameter int ADDR_WIDTH = $clog2(BUF_BYTES / KEEP_WIDTH),
    parameter int LEN_WIDTH  = $clog2(BUF_BYTES) + 1
) (
    input  logic                  logic_clk,
    input  logic                  logic_rst_n,
    input  logic                  wr_v_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  send_v_i,
    input  logic [LEN_WIDTH-1:0]  send_len_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] tx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] tx_axis_tkeep,
    output logic                  tx_axis_tvalid,
    input  logic                  tx_axis_tready,
    output logic                  tx_axis_tlast,
    output logic                  tx_axis_tuser
);

    localparam int                   c_depth   = BUF_BYTES / KEEP_WIDTH;
    localparam logic [LEN_WIDTH-1:0] c_max_len = LEN_WIDTH'(BUF_BYTES);
    localparam logic [LEN_WIDTH-1:0] c_keep_w  = LEN_WIDTH'(KEEP_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_rd_pend;
    logic                  r_sk_v;
    logic                  r_abort;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [LEN_WIDTH-1:0]  r_rd_cnt;
    logic [LEN_WIDTH-1:0]  r_out_idx;
    logic [LEN_WIDTH-1:0]  r_last_idx;
    logic [KEEP_WIDTH-1:0] r_last_keep;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_tuser;
    logic                  r_err;

    logic                  w_busy;
    logic                  w_hs;
    logic                  w_last_hs;
    logic                  w_len_ok;
    logic                  w_accept;
    logic                  w_abort_eff;
    logic                  w_out_free;
    logic                  w_rd_en;
    logic [1:0]            w_occ;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [LEN_WIDTH-1:0]  w_len_rem;
    logic [KEEP_WIDTH-1:0] w_len_keep;
    logic [KEEP_WIDTH-1:0] w_beat_keep;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_hs        = r_tvalid && tx_axis_tready;
    assign w_last_hs   = w_hs && r_tlast;
    assign w_len_ok    = (send_len_i != '0) && (send_len_i <= c_max_len);
    assign w_accept    = !w_busy && send_v_i && w_len_ok;
    assign w_abort_eff = r_abort || (w_busy && abort_i);
    assign w_out_free  = !r_tvalid || w_hs;
    assign w_occ       = 2'(r_tvalid) + 2'(r_sk_v) + 2'(r_rd_pend);
    assign w_rd_addr   = w_busy ? r_rd_addr : '0;
    assign w_len_rem   = send_len_i % c_keep_w;
    assign w_beat_keep = (r_out_idx == r_last_idx) ? r_last_keep : '1;
    assign w_load_data = r_sk_v ? r_skid : r_rd_data;

    // Output register + skid + one in-flight read never exceed two words once
    // this cycle's handshake is accounted for, so the RAM can run every cycle.
    assign w_rd_en = w_accept ||
                     (w_busy && !w_abort_eff && (r_rd_cnt <= r_last_idx) &&
                      (w_occ < (2'd2 + {1'b0, w_hs})));

    always_comb begin
        w_len_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_len_keep[i] = (w_len_rem == '0) || (LEN_WIDTH'(i) < w_len_rem);
        end
    end

    always_ff @(posedge logic_clk) begin
        if (wr_v_i && !w_busy) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            r_state     <= ST_IDLE;
            r_skid      <= '0;
            r_rd_pend   <= 1'b0;
            r_sk_v      <= 1'b0;
            r_abort     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_cnt    <= '0;
            r_out_idx   <= '0;
            r_last_idx  <= '0;
            r_last_keep <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err     <= !w_busy && send_v_i && !w_len_ok;
            r_rd_pend <= w_rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_FILL;
                        r_rd_addr   <= ADDR_WIDTH'(1);
                        r_rd_cnt    <= LEN_WIDTH'(1);
                        r_out_idx   <= '0;
                        r_last_idx  <= (send_len_i - LEN_WIDTH'(1)) / c_keep_w;
                        r_last_keep <= w_len_keep;
                        r_abort     <= 1'b0;
                        r_sk_v      <= 1'b0;
                    end
                end
                default: begin
                    if (r_state == ST_FILL) begin
                        r_state <= ST_STREAM;
                    end
                    if (w_rd_en) begin
                        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                        r_rd_cnt  <= r_rd_cnt + LEN_WIDTH'(1);
                    end
                    if (w_last_hs) begin
                        r_state  <= ST_IDLE;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_tuser  <= 1'b0;
                        r_sk_v   <= 1'b0;
                        r_abort  <= 1'b0;
                    end else begin
                        if (abort_i) begin
                            r_abort <= 1'b1;
                        end
                        if (w_out_free) begin
                            if (r_sk_v || r_rd_pend) begin
                                r_tvalid <= 1'b1;
                                r_tdata  <= w_load_data;
                                r_tkeep  <= w_beat_keep;
                                r_tlast  <= (r_out_idx == r_last_idx) || w_abort_eff;
                                r_tuser  <= w_abort_eff;
                                if (r_out_idx != '1) begin
                                    r_out_idx <= r_out_idx + LEN_WIDTH'(1);
                                end
                                if (r_sk_v) begin
                                    r_sk_v <= r_rd_pend;
                                    r_skid <= r_rd_data;
                                end
                            end else begin
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                                r_tuser  <= 1'b0;
                            end
                        end else begin
                            // Stalled beat holds; the arriving read parks in the skid.
                            if (r_rd_pend) begin
                                r_sk_v <= 1'b1;
                                r_skid <= r_rd_data;
                            end
                            if (r_tlast && w_abort_eff) begin
                                r_tuser <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign wr_ready_o     = !w_busy;
    assign busy_o         = w_busy;
    assign done_o         = w_last_hs;
    assign err_o          = r_err;
    assign tx_axis_tdata  = r_tdata;
    assign tx_axis_tkeep  = r_tkeep;
    assign tx_axis_tvalid = r_tvalid;
    assign tx_axis_tlast  = r_tlast;
    assign tx_axis_tuser  = r_tuser;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_frame_streamer
// Purpose  : Directed self-checking bench for eth_tx_frame_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_streamer;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int AW = 8;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_v;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          send_v;
    logic [LW-1:0] send_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    always #5 clk = ~clk;

    eth_tx_frame_streamer dut (
        .logic_clk      (clk),
        .logic_rst_n    (rst_n),
        .wr_v_i         (wr_v),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .wr_ready_o     (wr_ready),
        .send_v_i       (send_v),
        .send_len_i     (send_len),
        .abort_i        (abort),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .tx_axis_tdata  (tdata),
        .tx_axis_tkeep  (tkeep),
        .tx_axis_tvalid (tvalid),
        .tx_axis_tready (tready),
        .tx_axis_tlast  (tlast),
        .tx_axis_tuser  (tuser)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] cap_data [16];
    logic [KW-1:0] cap_keep [16];
    logic          cap_last [16];
    logic          cap_user [16];
    int            nb, first_c, done_cnt, done_beat, viol;
    logic          timed_out, busy_after, valid_after;
    logic [3:0]    pat = 4'b1001;  // tready per cycle index mod 4: 1,0,0,1

    function automatic logic [DW-1:0] word(input int k);
        return 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
    endfunction

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); wr_v = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk); wr_v = 1'b0;
    endtask

    // Issues a send and records every handshaken beat plus timing facts.
    task automatic run_frame(input logic [LW-1:0] len, input int mode, input int abort_beat);
        int c, bi; logic fin, pv, pr, pl; logic [DW-1:0] pd; logic [KW-1:0] pk;
        nb = 0; first_c = -1; done_cnt = 0; done_beat = -1; viol = 0;
        c = 0; bi = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pk = '0;
        @(negedge clk); send_v = 1'b1; send_len = len; tready = 1'b1;
        while (!fin && c < 200) begin
            @(negedge clk); c++; send_v = 1'b0;
            tready = (mode == 0) ? 1'b1 : pat[c % 4];
            abort  = (abort_beat >= 0) && tvalid && tready && (bi == abort_beat);
            #1;
            if (tvalid && first_c < 0) first_c = c;
            if (pv && !pr && tvalid && (tdata !== pd || tkeep !== pk || tlast !== pl)) viol++;
            if (tvalid && tready) begin
                if (nb < 16) begin
                    cap_data[nb] = tdata; cap_keep[nb] = tkeep;
                    cap_last[nb] = tlast; cap_user[nb] = tuser;
                end
                nb++; bi++;
                if (tlast) fin = 1'b1;
            end
            if (done) begin done_cnt++; done_beat = bi - 1; end
            pv = tvalid; pr = tready; pd = tdata; pk = tkeep; pl = tlast;
        end
        timed_out = !fin;
        @(negedge clk); abort = 1'b0; tready = 1'b1; #1;
        busy_after = busy; valid_after = tvalid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        checks++; if ({busy, done, err, tlast, tuser} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, err, tlast, tuser}); end
        checks++; if ({tdata, tkeep} !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", tdata, tkeep); end
        for (int k = 0; k < 8; k++) write_word(AW'(k), word(k));
    endtask

    task automatic test_basic();
        run_frame(12'd13, 0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got timeout want frame end"); end
        checks++; if (nb !== 2) begin errors++; $display("FAIL basic_nbeats got %0d want 2", nb); end
        checks++; if (first_c !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first_c); end
        checks++; if (cap_data[0] !== 64'h0706050403020100 || cap_keep[0] !== 8'hFF || cap_last[0] !== 1'b0)
            begin errors++; $display("FAIL basic_beat0 got %h/%h/%b want 0706050403020100/ff/0", cap_data[0], cap_keep[0], cap_last[0]); end
        checks++; if (cap_data[1] !== 64'h0F0E0D0C0B0A0908 || cap_keep[1] !== 8'h1F || cap_last[1] !== 1'b1 || cap_user[1] !== 1'b0)
            begin errors++; $display("FAIL basic_beat1 got %h/%h/%b/%b want 0f0e0d0c0b0a0908/1f/1/0", cap_data[1], cap_keep[1], cap_last[1], cap_user[1]); end
        checks++; if (done_cnt !== 1 || done_beat !== 1) begin errors++; $display("FAIL basic_done got %0d@%0d want 1@1", done_cnt, done_beat); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy_after); end
    endtask

    task automatic test_single();
        run_frame(12'd8, 0, -1);
        checks++; if (nb !== 1) begin errors++; $display("FAIL single_nbeats got %0d want 1", nb); end
        checks++; if (cap_data[0] !== word(0) || cap_keep[0] !== 8'hFF || cap_last[0] !== 1'b1)
            begin errors++; $display("FAIL single_beat got %h/%h/%b want %h/ff/1", cap_data[0], cap_keep[0], cap_last[0], word(0)); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_len_error();
        logic [LW-1:0] lens [2];
        lens[0] = 12'd0; lens[1] = 12'd2049;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); send_v = 1'b1; send_len = lens[i];
            @(negedge clk); send_v = 1'b0; #1;
            checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_pulse len=%0d got err=%b busy=%b want 1/0", lens[i], err, busy); end
            @(negedge clk); #1;
            checks++; if (err !== 1'b0 || tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_after len=%0d got err=%b tvalid=%b busy=%b want 0/0/0", lens[i], err, tvalid, busy); end
        end
    endtask

    task automatic test_backpressure();
        int bad_last;
        run_frame(12'd64, 1, -1);
        checks++; if (nb !== 8 || timed_out) begin errors++; $display("FAIL bp_nbeats got %0d (timeout=%b) want 8", nb, timed_out); end
        checks++; if (first_c !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", first_c); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_stall_stability got %0d changes want 0", viol); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (cap_data[k] !== word(k) || cap_keep[k] !== 8'hFF)
                begin errors++; $display("FAIL bp_beat%0d got %h/%h want %h/ff", k, cap_data[k], cap_keep[k], word(k)); end
        end
        bad_last = 0;
        for (int k = 0; k < 8; k++) if (cap_last[k] !== (k == 7)) bad_last++;
        checks++; if (bad_last !== 0) begin errors++; $display("FAIL bp_tlast got %0d misplaced want 0", bad_last); end
        checks++; if (done_cnt !== 1 || done_beat !== 7) begin errors++; $display("FAIL bp_done got %0d@%0d want 1@7", done_cnt, done_beat); end
    endtask

    task automatic test_abort();
        run_frame(12'd64, 0, 2);
        checks++; if (nb !== 4) begin errors++; $display("FAIL abort_nbeats got %0d want 4", nb); end
        checks++; if (cap_last[2] !== 1'b0 || cap_user[2] !== 1'b0) begin errors++; $display("FAIL abort_beat2 got last=%b user=%b want 0/0", cap_last[2], cap_user[2]); end
        checks++; if (cap_last[3] !== 1'b1 || cap_user[3] !== 1'b1 || cap_keep[3] !== 8'hFF || cap_data[3] !== word(3))
            begin errors++; $display("FAIL abort_beat3 got %b/%b/%h/%h want 1/1/ff/%h", cap_last[3], cap_user[3], cap_keep[3], cap_data[3], word(3)); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_done got %0d want 1", done_cnt); end
        checks++; if (busy_after !== 1'b0 || valid_after !== 1'b0) begin errors++; $display("FAIL abort_after got busy=%b tvalid=%b want 0/0", busy_after, valid_after); end
        run_frame(12'd13, 0, -1);
        checks++; if (nb !== 2 || cap_user[1] !== 1'b0 || cap_keep[1] !== 8'h1F)
            begin errors++; $display("FAIL abort_resend got nb=%0d user=%b keep=%h want 2/0/1f", nb, cap_user[1], cap_keep[1]); end
    endtask

    task automatic test_busy_ignore();
        int cnt; logic fin; logic [DW-1:0] d0;
        @(negedge clk); send_v = 1'b1; send_len = 12'd64; tready = 1'b0;
        @(negedge clk); send_v = 1'b0;
        repeat (3) @(negedge clk);
        wr_v = 1'b1; wr_addr = '0; wr_data = 64'hDEADBEEFCAFEF00D; send_v = 1'b1; send_len = 12'd13; #1;
        checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_wr_ready got wr_ready=%b busy=%b want 0/1", wr_ready, busy); end
        @(negedge clk); wr_v = 1'b0; send_v = 1'b0; #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL busy_send_err got %b want 0", err); end
        tready = 1'b1; cnt = 0; fin = 1'b0; d0 = '0;
        for (int c = 0; c < 100 && !fin; c++) begin
            #1;
            if (tvalid && tready) begin
                if (cnt == 0) d0 = tdata;
                cnt++;
                if (tlast) fin = 1'b1;
            end
            @(negedge clk);
        end
        checks++; if (!fin || cnt !== 8 || d0 !== word(0)) begin errors++; $display("FAIL busy_frame got fin=%b beats=%0d d0=%h want 1/8/%h", fin, cnt, d0, word(0)); end
        run_frame(12'd13, 0, -1);
        checks++; if (cap_data[0] !== word(0)) begin errors++; $display("FAIL busy_write_ignored got %h want %h", cap_data[0], word(0)); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); send_v = 1'b1; send_len = 12'd64; tready = 1'b1;
        @(negedge clk); send_v = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_streaming got tvalid=%b want 1", tvalid); end
        rst_n = 1'b0; #1;
        checks++; if (tvalid !== 1'b0 || tlast !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got tvalid=%b tlast=%b wr_ready=%b busy=%b want 0/0/1/0", tvalid, tlast, wr_ready, busy); end
        @(negedge clk); rst_n = 1'b1;
        run_frame(12'd13, 0, -1);
        checks++; if (nb !== 2 || cap_data[1] !== word(1) || cap_keep[1] !== 8'h1F || cap_last[1] !== 1'b1)
            begin errors++; $display("FAIL rstmid_resend got nb=%0d %h/%h/%b want 2 %h/1f/1", nb, cap_data[1], cap_keep[1], cap_last[1], word(1)); end
    endtask

    initial begin
        wr_v = 1'b0; wr_addr = '0; wr_data = '0; send_v = 1'b0; send_len = '0;
        abort = 1'b0; tready = 1'b1;
        test_reset();
        test_basic();
        test_single();
        test_len_error();
        test_backpressure();
        test_abort();
        test_busy_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
